stopwatch_display: RTL



---
 rtl/stopwatch_display_if.sv | 23 ++
 rtl/stopwatch_display.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/stopwatch_display_if.sv
// Display-side signal bundle for stopwatch_display: binary time and adjust
// controls in, active-low segment/anode drive out.
interface stopwatch_display_if;
    logic [5:0] minutes;
    logic [5:0] seconds;
    logic       adj;
    logic       sel;
    logic [6:0] seg;
    logic       dp;
    logic [3:0] an;

    // Upstream side: supplies time and adjust controls, observes display drive
    modport master (
        output minutes, seconds, adj, sel,
        input  seg, dp, an
    );

    // Display driver side
    modport slave (
        input  minutes, seconds, adj, sel,
        output seg, dp, an
    );
endinterface

// File: rtl/stopwatch_display.sv
// Four-digit multiplexed seven-segment driver for the stopwatch. Converts the
// binary minutes/seconds to BCD once per frame with a subtract-by-10 engine,
// scans the digits and blinks the field under adjustment.
module stopwatch_display #(
    parameter int SCAN_DIV  = 100000,
    parameter int BLINK_DIV = 25000000
) (
    input  logic                 clk_in,
    input  logic                 rst,
    stopwatch_display_if.slave   bus
);
    localparam int SCAN_W  = (SCAN_DIV  > 1) ? $clog2(SCAN_DIV)  : 1;
    localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    typedef enum logic [2:0] {IDLE, LATCH, CONV_MIN, CONV_SEC, COMMIT} state_t;

    // Timebase
    logic [SCAN_W-1:0]  scan_cnt_q, scan_cnt_d;
    logic [1:0]         dig_q, dig_d;
    logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
    logic               blink_on_q, blink_on_d;
    logic               scan_tc, blink_tc, wrap;

    // Conversion engine
    state_t             state_q, state_d;
    logic               start_q, start_d;
    logic [5:0]         min_w_q, min_w_d, sec_w_q, sec_w_d;
    logic [3:0]         min_t_q, min_t_d, sec_t_q, sec_t_d;
    logic [15:0]        disp_q, disp_d;   // {min tens, min ones, sec tens, sec ones}

    // Output stage
    logic [3:0]         an_q, an_d;
    logic [6:0]         seg_q, seg_d;
    logic               dp_q, dp_d;
    logic [3:0]         cur_digit;
    logic               blank;

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        case (d)
            4'd0:    return 7'b1000000;
            4'd1:    return 7'b1111001;
            4'd2:    return 7'b0100100;
            4'd3:    return 7'b0110000;
            4'd4:    return 7'b0011001;
            4'd5:    return 7'b0010010;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1111000;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    assign scan_tc  = (scan_cnt_q == SCAN_W'(SCAN_DIV - 1));
    assign blink_tc = (blink_cnt_q == BLINK_W'(BLINK_DIV - 1));
    assign wrap     = scan_tc && (dig_q == 2'd3);

    // Scan and blink counters advance every cycle
    always_comb begin
        scan_cnt_d  = scan_tc  ? '0 : scan_cnt_q + 1'b1;
        dig_d       = scan_tc  ? dig_q + 2'd1 : dig_q;
        blink_cnt_d = blink_tc ? '0 : blink_cnt_q + 1'b1;
        blink_on_d  = blink_tc ? ~blink_on_q : blink_on_q;
    end

    // Next-state logic for the conversion FSM
    always_comb begin
        // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
        state_d = state_q;
        start_d = 1'b0;
        case (state_q)
            IDLE:     if (wrap || start_q)   state_d = LATCH;
            LATCH:                           state_d = CONV_MIN;
            CONV_MIN: if (min_w_q < 6'd10)   state_d = CONV_SEC;
            CONV_SEC: if (sec_w_q < 6'd10)   state_d = COMMIT;
            COMMIT:                          state_d = IDLE;
            default:                         state_d = IDLE;
        endcase
    end

    // FSM datapath actions: snapshot, subtract-by-10, commit to display register
    always_comb begin
        min_w_d = min_w_q;
        sec_w_d = sec_w_q;
        min_t_d = min_t_q;
        sec_t_d = sec_t_q;
        disp_d  = disp_q;
        case (state_q)
            LATCH: begin
                min_w_d = bus.minutes;
                sec_w_d = bus.seconds;
                min_t_d = 4'd0;
                sec_t_d = 4'd0;
            end
            CONV_MIN: if (min_w_q >= 6'd10) begin
                min_w_d = min_w_q - 6'd10;
                min_t_d = min_t_q + 4'd1;
            end
            CONV_SEC: if (sec_w_q >= 6'd10) begin
                sec_w_d = sec_w_q - 6'd10;
                sec_t_d = sec_t_q + 4'd1;
            end
            COMMIT: disp_d = {min_t_q, min_w_q[3:0], sec_t_q, sec_w_q[3:0]};
            default: ;
        endcase
    end

    // Digit select, blanking and segment decode ahead of the output flops
    always_comb begin
        case (dig_q)
            2'd0:    cur_digit = disp_q[3:0];
            2'd1:    cur_digit = disp_q[7:4];
            2'd2:    cur_digit = disp_q[11:8];
            default: cur_digit = disp_q[15:12];
        endcase
        // dig 2/3 are the minutes field (sel=0), dig 0/1 the seconds field (sel=1)
        blank = bus.adj && !blink_on_q && (dig_q[1] != bus.sel);
        an_d  = blank ? 4'b1111 : ~(4'b0001 << dig_q);
        seg_d = blank ? 7'b1111111 : seg_decode(cur_digit);
        dp_d  = blank ? 1'b1 : (dig_q != 2'd2);
    end

    // State, timebase, display register and output flops with synchronous reset
    always_ff @(posedge clk_in) begin
        // NOTE: sequential state uses <= so every flop samples pre-edge values.
        if (rst) begin
            scan_cnt_q  <= '0;
            dig_q       <= 2'd0;
            blink_cnt_q <= '0;
            blink_on_q  <= 1'b1;
            state_q     <= IDLE;
            start_q     <= 1'b1;
            disp_q      <= '0;
            an_q        <= 4'b1111;
            seg_q       <= 7'b1111111;
            dp_q        <= 1'b1;
        end else begin
            scan_cnt_q  <= scan_cnt_d;
            dig_q       <= dig_d;
            blink_cnt_q <= blink_cnt_d;
            blink_on_q  <= blink_on_d;
            state_q     <= state_d;
            start_q     <= start_d;
            disp_q      <= disp_d;
            an_q        <= an_d;
            seg_q       <= seg_d;
            dp_q        <= dp_d;
        end
    end

    // Conversion working registers
    always_ff @(posedge clk_in) begin
        // NOTE: no reset here on purpose; LATCH always loads these before they are read.
        min_w_q <= min_w_d;
        sec_w_q <= sec_w_d;
        min_t_q <= min_t_d;
        sec_t_q <= sec_t_d;
    end

    assign bus.an  = an_q;
    assign bus.seg = seg_q;
    assign bus.dp  = dp_q;
endmodule
